uart_upgrade_loader: RTL and testbench

Firmware-upgrade receiver that sits directly downstream of the `uart` receiver inside `soc`. It consumes the `rx_valid`/`rx_data` byte stream and parses a framed image: sync byte, word count, payload and checksum. It packs the payload into 32-bit little-endian words and writes them sequentially into instruction memory, holding the CPU while it does so. On completion it returns a one-byte ACK or NAK through the `uart` transmitter's `tx_valid`/`tx_data` port.

---
 rtl/uart_upgrade_loader.sv | 180 ++++++++++++++++++
 tb/tb_uart_upgrade_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_upgrade_loader.sv
// uart_upgrade_loader
//   Firmware-upgrade receiver. It parses a framed image from the uart byte
//   stream: 0xA5, LEN_L, LEN_H, then LEN*4 payload bytes, then CSUM. Payload
//   bytes are packed little-endian into words and written sequentially into
//   imem while the CPU is held. When the frame ends, a one-byte ACK (0x4F) or
//   NAK (0x45) is returned to the uart transmitter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   upgrade_en        loader enable; dropping it aborts a frame in progress
//   rx_valid/rx_data  received byte strobe and data
//   tx_busy           transmitter busy; no tx request is made while it is set
//   tx_valid/tx_data  one-cycle transmit request with the ACK/NAK byte
//   imem_wr_*         one-cycle imem write strobe, word address, data
//   cpu_hold          high while a frame is in progress
//   done/err          sticky result of the last frame
module uart_upgrade_loader #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upgrade_en,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [XLEN-1:0]   imem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN0 = 3'd1;
  localparam logic [2:0] S_LEN1 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_ACK  = 3'd5;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_OK    = 8'h4F;
  localparam logic [7:0] ACK_NAK   = 8'h45;

  localparam int              GAP_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(TIMEOUT_CYC);
  localparam logic [16:0]      MAX_LEN = 17'(1) << ADDR_W;

  logic [2:0]       state;
  logic [7:0]       len_lo;
  logic [15:0]      len_q;
  logic [16:0]      wcnt;       // words written so far; also the next word address
  logic [1:0]       idx;
  logic [23:0]      byte_buf;   // lower three bytes of the word being assembled
  logic [7:0]       csum;
  logic [GAP_W-1:0] gap;
  logic [7:0]       ack_byte;

  logic [15:0]      len_full;
  logic             timed;

  assign len_full = {rx_data, len_lo};
  assign timed    = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len_q        <= '0;
      wcnt         <= '0;
      idx          <= '0;
      byte_buf     <= '0;
      csum         <= '0;
      gap          <= '0;
      ack_byte     <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_hold     <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      tx_valid   <= 1'b0;
      imem_wr_en <= 1'b0;

      // Abort outranks timeout, which outranks byte handling.
      if (state != S_IDLE && !upgrade_en) begin
        state    <= S_IDLE;
        cpu_hold <= 1'b0;
      end else if (timed && gap == GAP_MAX) begin
        err      <= 1'b1;
        ack_byte <= ACK_NAK;
        state    <= S_ACK;
      end else begin
        if (timed) gap <= rx_valid ? '0 : gap + 1'b1;

        case (state)
          S_IDLE: begin
            if (upgrade_en && rx_valid && rx_data == SYNC_BYTE) begin
              done     <= 1'b0;
              err      <= 1'b0;
              cpu_hold <= 1'b1;
              wcnt     <= '0;
              idx      <= '0;
              csum     <= '0;
              gap      <= '0;
              state    <= S_LEN0;
            end
          end
          S_LEN0: begin
            if (rx_valid) begin
              len_lo <= rx_data;
              state  <= S_LEN1;
            end
          end
          S_LEN1: begin
            if (rx_valid) begin
              len_q <= len_full;
              if ({1'b0, len_full} > MAX_LEN) begin
                err      <= 1'b1;
                ack_byte <= ACK_NAK;
                state    <= S_ACK;
              end else if (len_full == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_valid) begin
              csum <= csum + rx_data;
              idx  <= idx + 2'd1;
              case (idx)
                2'd0: byte_buf[7:0]   <= rx_data;
                2'd1: byte_buf[15:8]  <= rx_data;
                2'd2: byte_buf[23:16] <= rx_data;
                default: begin
                  imem_wr_en   <= 1'b1;
                  imem_wr_addr <= wcnt[ADDR_W-1:0];
                  imem_wr_data <= XLEN'({rx_data, byte_buf});
                  wcnt         <= wcnt + 17'd1;
                  if (wcnt + 17'd1 == {1'b0, len_q}) state <= S_CSUM;
                end
              endcase
            end
          end
          S_CSUM: begin
            if (rx_valid) begin
              if (rx_data == csum) begin
                done     <= 1'b1;
                ack_byte <= ACK_OK;
              end else begin
                err      <= 1'b1;
                ack_byte <= ACK_NAK;
              end
              state <= S_ACK;
            end
          end
          S_ACK: begin
            if (!tx_busy) begin
              tx_valid <= 1'b1;
              tx_data  <= ack_byte;
              cpu_hold <= 1'b0;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_upgrade_loader.sv
module tb_uart_upgrade_loader;

  localparam int ADDR_W  = 4;   // max image 16 words
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              upgrade_en;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_busy;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_wr_addr;
  logic [31:0]       imem_wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;

  uart_upgrade_loader #(.XLEN(32), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .upgrade_en(upgrade_en),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];
  int unsigned busy_viol = 0;

  always @(negedge clk) begin
    if (imem_wr_en) begin
      wr_addr_q.push_back(32'(imem_wr_addr));
      wr_data_q.push_back(imem_wr_data);
    end
    if (tx_valid) begin
      tx_q.push_back(tx_data);
      if (tx_busy) busy_viol++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is consumed plus one idle cycle.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    cycles(1);
  endtask

  task automatic send_frame(input logic [0:11][7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_byte(b[i]);
  endtask

  task automatic wait_tx(input int unsigned budget);
    int unsigned k;
    k = 0;
    while (tx_q.size() == 0 && k < budget) begin
      cycles(1);
      k++;
    end
  endtask

  typedef struct {
    string            name;
    int unsigned      n;
    logic [0:11][7:0] b;
    logic             exp_done;
    logic             exp_err;
    logic [7:0]       exp_ack;
    int unsigned      exp_nwr;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Payload 78 56 34 12 EF BE AD DE sums to 0x44C, so the good checksum is 0x4C.
    vecs[0] = '{name:"two_words_ok", n:12,
                b:{8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4C},
                exp_done:1'b1, exp_err:1'b0, exp_ack:8'h4F, exp_nwr:2, w0:32'h12345678, w1:32'hDEADBEEF};
    vecs[1] = '{name:"two_words_badsum", n:12,
                b:{8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h04},
                exp_done:1'b0, exp_err:1'b1, exp_ack:8'h45, exp_nwr:2, w0:32'h12345678, w1:32'hDEADBEEF};
    vecs[2] = '{name:"len0_ok", n:4,
                b:{8'hA5,8'h00,8'h00,8'h00,64'h0},
                exp_done:1'b1, exp_err:1'b0, exp_ack:8'h4F, exp_nwr:0, w0:32'h0, w1:32'h0};
    vecs[3] = '{name:"len0_badsum", n:4,
                b:{8'hA5,8'h00,8'h00,8'h01,64'h0},
                exp_done:1'b0, exp_err:1'b1, exp_ack:8'h45, exp_nwr:0, w0:32'h0, w1:32'h0};
    vecs[4] = '{name:"noise_then_one_word", n:10,
                b:{8'h11,8'h22,8'hA5,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0A,16'h0},
                exp_done:1'b1, exp_err:1'b0, exp_ack:8'h4F, exp_nwr:1, w0:32'h04030201, w1:32'h0};
    vecs[5] = '{name:"len_too_big", n:3,
                b:{8'hA5,8'h11,8'h00,72'h0},
                exp_done:1'b0, exp_err:1'b1, exp_ack:8'h45, exp_nwr:0, w0:32'h0, w1:32'h0};

    rst = 1'b1; upgrade_en = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_wr_en", 32'(imem_wr_en), 0);
    check("rst_wr_addr", 32'(imem_wr_addr), 0);
    check("rst_wr_data", imem_wr_data, 0);
    check("rst_cpu_hold", 32'(cpu_hold), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

    for (int unsigned v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(vecs[v].b, vecs[v].n);
      wait_tx(20);
      cycles(2);
      check({vecs[v].name, "_tx_count"}, tx_q.size(), 1);
      if (tx_q.size() > 0) check({vecs[v].name, "_ack"}, 32'(tx_q[0]), 32'(vecs[v].exp_ack));
      check({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
      check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_cpu_hold"}, 32'(cpu_hold), 0);
      check({vecs[v].name, "_nwr"}, wr_data_q.size(), vecs[v].exp_nwr);
      if (vecs[v].exp_nwr > 0 && wr_data_q.size() > 0) begin
        check({vecs[v].name, "_w0_addr"}, wr_addr_q[0], 0);
        check({vecs[v].name, "_w0_data"}, wr_data_q[0], vecs[v].w0);
      end
      if (vecs[v].exp_nwr > 1 && wr_data_q.size() > 1) begin
        check({vecs[v].name, "_w1_addr"}, wr_addr_q[1], 1);
        check({vecs[v].name, "_w1_data"}, wr_data_q[1], vecs[v].w1);
      end
    end

    // cpu_hold rises right after the sync byte; ACK held off while tx_busy.
    clear_mon();
    tx_busy = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hA5;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("hold_after_sync", 32'(cpu_hold), 1);
    cycles(1);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    cycles(200);
    check("busy_no_tx", tx_q.size(), 0);
    check("busy_hold", 32'(cpu_hold), 1);
    check("busy_done", 32'(done), 1);
    tx_busy = 1'b0;
    wait_tx(10);
    check("busy_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("busy_ack", 32'(tx_q[0]), 32'h4F);
    check("busy_hold_after", 32'(cpu_hold), 0);

    // Timeout after two payload bytes.
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    cycles(30);
    check("to_early_err", 32'(err), 0);
    check("to_early_tx", tx_q.size(), 0);
    wait_tx(40);
    cycles(1);
    check("to_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("to_ack", 32'(tx_q[0]), 32'h45);
    check("to_err", 32'(err), 1);
    check("to_nwr", wr_data_q.size(), 0);
    check("to_hold", 32'(cpu_hold), 0);

    // Disabled loader ignores a whole frame; sticky err from above survives.
    clear_mon();
    upgrade_en = 1'b0;
    send_frame({8'hA5,8'h01,8'h00,8'h01,8'h02,8'h03,8'h04,8'h0A,32'h0}, 8);
    cycles(5);
    check("dis_hold", 32'(cpu_hold), 0);
    check("dis_nwr", wr_data_q.size(), 0);
    check("dis_tx", tx_q.size(), 0);
    check("dis_err_kept", 32'(err), 1);

    // Abort mid-DATA: one word already written, no ACK.
    clear_mon();
    upgrade_en = 1'b1;
    send_frame({8'hA5,8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,32'h0}, 8);
    check("abort_hold_before", 32'(cpu_hold), 1);
    upgrade_en = 1'b0;
    cycles(1);
    check("abort_hold", 32'(cpu_hold), 0);
    upgrade_en = 1'b1;
    cycles(50);
    check("abort_tx", tx_q.size(), 0);
    check("abort_nwr", wr_data_q.size(), 1);
    check("abort_done", 32'(done), 0);
    check("abort_err", 32'(err), 0);

    // Reset mid-frame, then a clean LEN=1 frame restarts at address 0.
    clear_mon();
    send_frame({8'hA5,8'h02,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,32'h0}, 8);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    check("rst_mid_hold", 32'(cpu_hold), 0);
    check("rst_mid_wr_addr", 32'(imem_wr_addr), 0);
    check("rst_mid_wr_data", imem_wr_data, 0);
    clear_mon();
    send_frame({8'hA5,8'h01,8'h00,8'hDD,8'hCC,8'hBB,8'hAA,8'h0E,32'h0}, 8);
    wait_tx(20);
    cycles(2);
    check("rst_frame_nwr", wr_data_q.size(), 1);
    if (wr_data_q.size() > 0) begin
      check("rst_frame_addr", wr_addr_q[0], 0);
      check("rst_frame_data", wr_data_q[0], 32'hAABBCCDD);
    end
    check("rst_frame_tx_count", tx_q.size(), 1);
    if (tx_q.size() > 0) check("rst_frame_ack", 32'(tx_q[0]), 32'h4F);
    check("rst_frame_done", 32'(done), 1);

    check("tx_while_busy", busy_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
